data_ram_arbiter: RTL and testbench
===================================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 SHALL have parameter AddrBase, default 32'h0010_0000: byte base address of the RAM window.
REQ-002 SHALL have parameter Depth, default 128: RAM size in 32-bit words; window is [AddrBase, AddrBase+4*Depth).
REQ-003 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port host_req_i, input, 2: per-host request; bit h belongs to host h.
REQ-006 SHALL have port host_gnt_o, output, 2: per-host grant, same cycle as accepted request.
REQ-007 SHALL have port host_we_i, input, 2: per-host write enable.
REQ-008 SHALL have port host_be_i, input, 8: per-host byte enables, host h in [4h+3:4h].
REQ-009 SHALL have port host_addr_i, input, 64: per-host byte address, host h in [32h+31:32h].
REQ-010 SHALL have port host_wdata_i, input, 64: per-host write data, same packing as addresses.
REQ-011 SHALL have port host_rvalid_o, output, 2: per-host response valid.
REQ-012 SHALL have port host_err_o, output, 2: per-host error, qualified by host_rvalid_o.
REQ-013 SHALL have port host_rdata_o, output, 32: read data shared by both hosts, qualified by host_rvalid_o.
REQ-014 SHALL have port ram_req_o, output, 1: RAM request.
REQ-015 SHALL have port ram_we_o, output, 1: RAM write enable.
REQ-016 SHALL have port ram_be_o, output, 4: RAM byte enables.
REQ-017 SHALL have port ram_addr_o, output, 32: RAM byte offset.
REQ-018 SHALL have port ram_wdata_o, output, 32: RAM write data.
REQ-019 SHALL have port ram_rvalid_i, input, 1: RAM response valid, one cycle after ram_req_o.
REQ-020 SHALL have port ram_rdata_i, input, 32: RAM read data.

Function
REQ-021 SHALL grant at most one host per cycle; grant is combinational from host_req_i and the registered last_grant.
REQ-022 SHALL grant the sole requester when only one host requests, and SHALL grant none when neither requests.
REQ-023 SHALL, when both hosts request, grant the host not recorded in last_grant; last_grant updates on every grant.
REQ-024 SHALL drive the RAM-side we/be/wdata combinationally from the granted host, and SHALL drive them to 0 when no host is granted.
REQ-025 SHALL drive ram_addr_o as the granted address minus AddrBase, modulo 2^32.
REQ-026 SHALL, for an in-window address, assert ram_req_o in the grant cycle.
REQ-027 SHALL, for an out-of-window address, deassert ram_req_o and set a registered error-pending flag.
REQ-028 SHALL record the granted host in a registered owner field plus an owner-valid bit.
REQ-029 SHALL assert host_rvalid_o[owner] exactly one cycle after the grant: for in-window accesses when ram_rvalid_i=1, for errored accesses from the error-pending flag.
REQ-030 SHALL, on an error response, drive host_err_o[owner]=1 and host_rdata_o=0; otherwise host_err_o=0 and host_rdata_o=ram_rdata_i.
REQ-031 SHALL ignore ram_rvalid_i when owner-valid=0.
REQ-032 SHALL sustain back-to-back grants at one per cycle: a new grant and the previous response may occur in the same cycle.
REQ-033 SHALL provide write responses with rvalid exactly as for reads; rdata is don't-care on write responses.

Reset
REQ-034 SHALL, while rst_i=1, hold host_gnt_o=0, host_rvalid_o=0, host_err_o=0, host_rdata_o=0 and ram_req_o=0.
REQ-035 SHALL, on reset, clear owner-valid and error-pending, and set last_grant=1 so host 0 wins the first tie.
REQ-036 SHALL drop any response pending at reset; a ram_rvalid_i arriving in the first cycle after release SHALL produce no host_rvalid_o.

Verification
REQ-037 Both hosts request reads after reset at AddrBase+0x0 and AddrBase+0x4 -> the bench SHALL check:
- cycle 0: grant host 0, ram_addr_o=0x0;
- cycle 1: grant host 1, ram_addr_o=0x4;
- rvalid to host 0 in cycle 1 and to host 1 in cycle 2.
REQ-038 Both hosts hold requests for 6 cycles -> the bench SHALL check grants alternate 0,1,0,1,0,1 with no idle cycle.
REQ-039 Host 1 writes 0xDEADBEEF to AddrBase+0x8 with be=4'b0011, then reads it back -> the bench SHALL check ram_be_o=4'b0011 and host_rdata_o=0x0000BEEF, with RAM preloaded to 0.
REQ-040 Host 0 reads 32'h0000_0000 (outside window) -> the bench SHALL check:
- grant with ram_req_o=0;
- next cycle host_rvalid_o[0]=1, host_err_o[0]=1, host_rdata_o=0.
REQ-041 The bench SHALL assert rst_i the cycle after a grant -> it SHALL check no host_rvalid_o follows, and the first tie after release goes to host 0.
REQ-042 Host 0 reads AddrBase+4*Depth-4, then AddrBase+4*Depth -> the bench SHALL check the first is in-window with err=0 and the second returns err=1.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// Bundle of host-side and RAM-side signals around the two-host data RAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (hosts plus RAM).
interface data_ram_arbiter_if;
  // Host side, two hosts packed per bit/lane
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_addr_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [1:0]  host_err_o;
  logic [31:0] host_rdata_o;
  // RAM side
  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    input  ram_rvalid_i, ram_rdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
    output ram_rvalid_i, ram_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-host round-robin arbiter in front of a single-port data RAM.
// One grant per cycle, combinational from the requests and the last winner.
// Out-of-window accesses never reach the RAM and are answered with an error
// one cycle later; in-window accesses are answered when the RAM returns rvalid.
module data_ram_arbiter #(
  parameter logic [31:0] AddrBase = 32'h0010_0000,
  parameter int unsigned Depth    = 128
) (
  input logic              clk_i,
  input logic              rst_i,
  data_ram_arbiter_if.slave bus
);

  // Window size in bytes, one extra bit so 4*Depth never wraps the compare.
  localparam logic [32:0] WinBytes = 33'(4 * Depth);

  // Per-host unpacked views of the packed host buses
  logic [31:0] h_addr  [2];
  logic [31:0] h_wdata [2];
  logic [3:0]  h_be    [2];
  logic        h_we    [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_host
      assign h_addr[gi]  = bus.host_addr_i[32*gi +: 32];
      assign h_wdata[gi] = bus.host_wdata_i[32*gi +: 32];
      assign h_be[gi]    = bus.host_be_i[4*gi +: 4];
      assign h_we[gi]    = bus.host_we_i[gi];
    end
  endgenerate

  // Registered state
  logic last_grant_q, last_grant_d;   // host that won the most recent grant
  logic owner_q, owner_d;             // host owed a response next cycle
  logic owner_valid_q, owner_valid_d; // a response is owed next cycle
  logic err_pend_q, err_pend_d;       // the owed response is an error

  // Combinational datapath
  logic [1:0]  gnt;
  logic        gnt_any;
  logic        sel;
  logic [31:0] offset;
  logic        in_window;
  logic        rsp_valid;
  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata;

  // Arbitration: sole requester wins, a tie goes to the host that did not win last.
  // Nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      case (bus.host_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    gnt_any = |gnt;
    sel     = gnt[1];
  end

  // Address translation and window check for the granted host.
  // Addresses below the base wrap to a large offset and so fail the compare.
  always_comb begin
    offset    = h_addr[sel] - AddrBase;
    in_window = ({1'b0, offset} < WinBytes);
  end

  // RAM-side request, forwarded from the granted host, all zero when idle
  always_comb begin
    bus.ram_req_o   = gnt_any & in_window;
    bus.ram_we_o    = gnt_any & h_we[sel];
    bus.ram_be_o    = gnt_any ? h_be[sel]    : 4'h0;
    bus.ram_wdata_o = gnt_any ? h_wdata[sel] : 32'h0;
    bus.ram_addr_o  = gnt_any ? offset       : 32'h0;
    bus.host_gnt_o  = gnt;
  end

  // Next-state: remember who was granted and whether its answer is an error
  always_comb begin
    last_grant_d  = gnt_any ? sel : last_grant_q;
    owner_d       = gnt_any ? sel : owner_q;
    owner_valid_d = gnt_any;
    err_pend_d    = gnt_any & ~in_window;
  end

  // State registers; reset drops any owed response and favours host 0 next tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
      err_pend_q    <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      err_pend_q    <= err_pend_d;
    end
  end

  // Response routing to the owner; RAM rvalid is ignored when nothing is owed
  always_comb begin
    rsp_valid  = owner_valid_q & (err_pend_q | bus.ram_rvalid_i);
    rvalid_vec = {owner_q, ~owner_q} & {2{rsp_valid}};
    err_vec    = rvalid_vec & {2{err_pend_q}};
    rdata      = (rsp_valid && !err_pend_q) ? bus.ram_rdata_i : 32'h0;
    bus.host_rvalid_o = rvalid_vec;
    bus.host_err_o    = err_vec;
    bus.host_rdata_o  = rdata;
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a scoreboard: stimulus pushes the
// expected grant/response into queues, a negedge monitor pops and compares.
module tb_data_ram_arbiter;

  localparam logic [31:0] AB = 32'h0010_0000;
  localparam int unsigned DEP = 128;

  logic clk = 1'b0;
  logic rst;
  logic inject;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_arbiter_if bus();

  data_ram_arbiter #(.AddrBase(AB), .Depth(DEP)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  // Simple RAM model: one-cycle response, read-before-write, byte enables
  logic [31:0] mem [0:127];
  logic        ram_rv_q = 1'b0;
  logic [31:0] ram_rd_q = 32'h0;
  logic [6:0]  ram_idx;
  assign ram_idx = bus.ram_addr_o[8:2];
  assign bus.ram_rvalid_i = ram_rv_q | inject;
  assign bus.ram_rdata_i  = ram_rd_q;

  always @(posedge clk) begin
    ram_rv_q <= bus.ram_req_o;
    if (bus.ram_req_o) begin
      ram_rd_q <= mem[ram_idx];
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[ram_idx][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [1:0]  err;
    logic [31:0] rdata;
    bit          chk;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  // Monitor: compare every presented grant/response against the queues
  gexp_t g;
  rexp_t r;
  always @(negedge clk) begin
    if (bus.host_gnt_o != 2'b00) begin
      tests++;
      if (gq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_grant cyc=%0d got gnt=%b want none", cyc, bus.host_gnt_o);
      end else begin
        g = gq.pop_front();
        if (g.cyc != cyc || g.gnt !== bus.host_gnt_o || g.req !== bus.ram_req_o ||
            g.addr !== bus.ram_addr_o || g.we !== bus.ram_we_o || g.be !== bus.ram_be_o ||
            g.wdata !== bus.ram_wdata_o) begin
          fails++;
          $display("FAIL grant cyc=%0d got gnt=%b req=%b addr=%h we=%b be=%b wd=%h want cyc=%0d gnt=%b req=%b addr=%h we=%b be=%b wd=%h",
                   cyc, bus.host_gnt_o, bus.ram_req_o, bus.ram_addr_o, bus.ram_we_o, bus.ram_be_o,
                   bus.ram_wdata_o, g.cyc, g.gnt, g.req, g.addr, g.we, g.be, g.wdata);
        end else begin
          $display("[TB] cyc %0d grant gnt=%b ram_req=%b addr=%h ok", cyc, g.gnt, g.req, g.addr);
        end
      end
    end else begin
      tests++;
      if (bus.ram_req_o !== 1'b0 || bus.ram_we_o !== 1'b0 || bus.ram_be_o !== 4'h0 ||
          bus.ram_wdata_o !== 32'h0) begin
        fails++;
        $display("FAIL idle_ram cyc=%0d got req=%b we=%b be=%b wd=%h want all zero",
                 cyc, bus.ram_req_o, bus.ram_we_o, bus.ram_be_o, bus.ram_wdata_o);
      end
    end

    if (bus.host_rvalid_o != 2'b00) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid cyc=%0d got rvalid=%b err=%b want none",
                 cyc, bus.host_rvalid_o, bus.host_err_o);
      end else begin
        r = rq.pop_front();
        if (r.cyc != cyc || r.rv !== bus.host_rvalid_o || r.err !== bus.host_err_o ||
            (r.chk && r.rdata !== bus.host_rdata_o)) begin
          fails++;
          $display("FAIL response cyc=%0d got rvalid=%b err=%b rdata=%h want cyc=%0d rvalid=%b err=%b rdata=%h",
                   cyc, bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o,
                   r.cyc, r.rv, r.err, r.rdata);
        end else begin
          $display("[TB] cyc %0d response rvalid=%b err=%b rdata=%h ok",
                   cyc, r.rv, r.err, bus.host_rdata_o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [7:0] be,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] w0, input logic [31:0] w1);
    bus.host_req_i   = req;
    bus.host_we_i    = we;
    bus.host_be_i    = be;
    bus.host_addr_i  = {a1, a0};
    bus.host_wdata_i = {w1, w0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Push the expected grant for this cycle and, if owed, the response next cycle
  task automatic exp_acc(input int h, input logic rq_exp, input logic [31:0] off,
                         input logic we, input logic [3:0] be, input logic [31:0] wd,
                         input bit rsp, input logic err, input logic [31:0] rd, input bit chk);
    gexp_t ge;
    rexp_t re;
    ge.cyc = cyc;
    ge.gnt = (h == 0) ? 2'b01 : 2'b10;
    ge.req = rq_exp;
    ge.addr = off;
    ge.we = we;
    ge.be = be;
    ge.wdata = wd;
    gq.push_back(ge);
    if (rsp) begin
      re.cyc = cyc + 1;
      re.rv = ge.gnt;
      re.err = err ? ge.gnt : 2'b00;
      re.rdata = rd;
      re.chk = chk;
      rq.push_back(re);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end else begin
      $display("[TB] %s = %h ok", name, got);
    end
  endtask

  int exp_host [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rst = 1'b1;
    inject = 1'b0;
    idle();
    tick();
    tick();

    // Reset holds every output quiet even with both hosts requesting
    drive(2'b11, 2'b00, 8'hFF, AB, AB + 32'h4, 32'h0, 32'h0);
    #2;
    check("reset_gnt",     {30'h0, bus.host_gnt_o},    32'h0);
    check("reset_rvalid",  {30'h0, bus.host_rvalid_o}, 32'h0);
    check("reset_err",     {30'h0, bus.host_err_o},    32'h0);
    check("reset_rdata",   bus.host_rdata_o,           32'h0);
    check("reset_ram_req", {31'h0, bus.ram_req_o},     32'h0);

    // Both hosts read after reset: host 0 first, then host 1
    tick();
    rst = 1'b0;
    drive(2'b11, 2'b00, 8'hFF, AB, AB + 32'h4, 32'h0, 32'h0);
    exp_acc(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    exp_acc(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    idle();

    // Sustained tie for six cycles: strict alternation, no bubbles
    tick();
    drive(2'b11, 2'b00, 8'hFF, AB + 32'h10, AB + 32'h14, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      exp_acc(exp_host[i], 1'b1, (exp_host[i] == 0) ? 32'h10 : 32'h14,
              1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    end
    tick();
    idle();

    // Host 1 partial write then read-back of the same word
    tick();
    drive(2'b10, 2'b10, {4'b0011, 4'hF}, 32'h0, AB + 32'h8, 32'h0, 32'hDEAD_BEEF);
    exp_acc(1, 1'b1, 32'h8, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'b10, 2'b00, 8'hFF, 32'h0, AB + 32'h8, 32'h0, 32'h0);
    exp_acc(1, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0000_BEEF, 1'b1);
    tick();
    idle();

    // Out-of-window read from host 0, followed back-to-back by a host 1 read
    tick();
    drive(2'b01, 2'b00, 8'hFF, 32'h0, 32'h0, 32'h0, 32'h0);
    exp_acc(0, 1'b0, 32'hFFF0_0000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    tick();
    drive(2'b10, 2'b00, 8'hFF, 32'h0, AB + 32'h8, 32'h0, 32'h0);
    exp_acc(1, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0000_BEEF, 1'b1);
    tick();
    idle();

    // Window edges: last word is in, first word past the end is an error
    tick();
    drive(2'b01, 2'b00, 8'hFF, AB + 32'h1FC, 32'h0, 32'h0, 32'h0);
    exp_acc(0, 1'b1, 32'h1FC, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(2'b01, 2'b00, 8'hFF, AB + 32'h200, 32'h0, 32'h0, 32'h0);
    exp_acc(0, 1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    tick();
    idle();

    // Reset right after a grant: the owed response is dropped
    tick();
    drive(2'b01, 2'b00, 8'hFF, AB + 32'hC, 32'h0, 32'h0, 32'h0);
    exp_acc(0, 1'b1, 32'hC, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    #2;
    check("rst_drop_rvalid", {30'h0, bus.host_rvalid_o}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    inject = 1'b1;
    #2;
    check("release_stray_rvalid", {30'h0, bus.host_rvalid_o}, 32'h0);

    // First tie after release must go to host 0
    tick();
    inject = 1'b0;
    drive(2'b11, 2'b00, 8'hFF, AB + 32'h20, AB + 32'h24, 32'h0, 32'h0);
    exp_acc(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    tick();
    tick();

    check("grant_queue_left",    gq.size(), 32'h0);
    check("response_queue_left", rq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
